// File: rtl/arb_grant_collector_if.sv
// Handshake bundle between the round-robin arbiter, the grant collector and
// the downstream consumer of the arbitrated stream.
interface arb_grant_collector_if #(
  parameter int unsigned NUM_AGENTS = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned ID_WIDTH  = $clog2(NUM_AGENTS);
  localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

  logic [NUM_AGENTS-1:0]            grants_i;
  logic [NUM_AGENTS*DATA_WIDTH-1:0] data_i;
  logic                             yumi_o;
  logic [NUM_AGENTS-1:0]            ack_o;
  logic                             v_o;
  logic [DATA_WIDTH-1:0]            data_o;
  logic [ID_WIDTH-1:0]              id_o;
  logic                             ready_i;
  logic [CNT_WIDTH-1:0]             count_o;
  logic                             onehot_err_o;

  // Environment side: arbiter plus downstream consumer.
  modport master (
    output grants_i, data_i, ready_i,
    input  yumi_o, ack_o, v_o, data_o, id_o, count_o, onehot_err_o
  );

  // Collector side.
  modport slave (
    input  grants_i, data_i, ready_i,
    output yumi_o, ack_o, v_o, data_o, id_o, count_o, onehot_err_o
  );
endinterface

// File: rtl/arb_grant_collector.sv
// Muxes the granted agent's payload into a tagged fall-through FIFO and
// returns yumi to the arbiter; flags multi-hot grants stickily.
module arb_grant_collector #(
  parameter int unsigned NUM_AGENTS = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset,
  arb_grant_collector_if.slave  bus
);
  localparam int unsigned ID_WIDTH  = $clog2(NUM_AGENTS);
  localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_WIDTH = ID_WIDTH + DATA_WIDTH;

  logic                  grant_any;
  logic                  grant_ok;
  logic                  multi_hot;
  logic [ID_WIDTH-1:0]   id_enc;
  logic [DATA_WIDTH-1:0] data_sel;

  logic [ENT_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  onehot_err;
  logic                  full;
  logic                  enq;
  logic                  deq;

  always_comb begin
    grant_any = |bus.grants_i;
    // Clearing the lowest set bit leaves zero only for a one-hot vector.
    grant_ok  = grant_any &
                ((bus.grants_i & (bus.grants_i - NUM_AGENTS'(1))) == '0);
    multi_hot = grant_any & ~grant_ok;
  end

  always_comb begin
    id_enc   = '0;
    data_sel = '0;
    for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
      if (bus.grants_i[i]) begin
        id_enc   = ID_WIDTH'(i);
        data_sel = bus.data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Full blocks acceptance even if the head leaves this cycle, keeping
  // ready_i out of the yumi path.
  always_comb begin
    full = (count == CNT_WIDTH'(FIFO_DEPTH));
    enq  = grant_ok & ~full & ~reset;
    deq  = bus.v_o & bus.ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wr_ptr] <= {id_enc, data_sel};
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      onehot_err <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
      if (multi_hot) onehot_err <= 1'b1;
    end
  end

  always_comb begin
    bus.yumi_o              = enq;
    bus.ack_o               = bus.grants_i & {NUM_AGENTS{enq}};
    bus.v_o                 = (count != '0);
    {bus.id_o, bus.data_o}  = mem[rd_ptr];
    bus.count_o             = count;
    bus.onehot_err_o        = onehot_err;
  end
endmodule

// File: tb/tb_arb_grant_collector.sv
// Directed bench for arb_grant_collector: reset, single grant, fill/stall,
// full with dequeue, streaming wrap, multi-hot error and mid-cycle reset.
module tb_arb_grant_collector;
  localparam int unsigned NA = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned FD = 4;

  logic clk_i = 1'b0;
  logic reset;
  int   tests  = 0;
  int   errors = 0;

  arb_grant_collector_if #(.NUM_AGENTS(NA), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

  arb_grant_collector #(.NUM_AGENTS(NA), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk_i (clk_i),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic grant(input logic [NA-1:0] g);
    bus.grants_i = g;
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    bus.ready_i = 1'b0;
    bus.grants_i = '0;
    for (int k = 0; k < NA; k++) bus.data_i[k*DW +: DW] = 32'hA5A5_0000 + k;

    // Reset holds everything idle even with a legal grant present.
    #3;
    grant(16'h0004);
    check("rst_yumi", bus.yumi_o, 0);
    check("rst_ack", bus.ack_o, 0);
    check("rst_v", bus.v_o, 0);
    check("rst_count", bus.count_o, 0);
    check("rst_err", bus.onehot_err_o, 0);
    bus.grants_i = '0;
    @(negedge clk_i);
    reset = 1'b0;
    tick();

    // 1: single grant
    bus.ready_i = 1'b1;
    grant(16'h0004);
    check("t1_yumi", bus.yumi_o, 1);
    check("t1_ack", bus.ack_o, 16'h0004);
    tick();
    bus.grants_i = '0;
    check("t1_v", bus.v_o, 1);
    check("t1_id", bus.id_o, 2);
    check("t1_data", bus.data_o, 32'hA5A5_0002);
    check("t1_count", bus.count_o, 1);
    tick();
    check("t1_count_drained", bus.count_o, 0);
    check("t1_v_drained", bus.v_o, 0);

    // 2: fill and stall
    bus.ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      grant(16'(1 << i));
      check("t2_fill_yumi", bus.yumi_o, 1);
      tick();
    end
    check("t2_count_full", bus.count_o, 4);
    grant(16'h0010);
    check("t2_full_yumi", bus.yumi_o, 0);
    check("t2_full_ack", bus.ack_o, 0);
    bus.ready_i = 1'b1;
    #1;
    check("t2_full_ready_yumi", bus.yumi_o, 0);
    check("t2_head0", bus.id_o, 0);
    tick();
    check("t2_head1", bus.id_o, 1);
    check("t2_count3", bus.count_o, 3);
    check("t2_g4_yumi", bus.yumi_o, 1);
    check("t2_g4_ack", bus.ack_o, 16'h0010);
    tick();
    bus.grants_i = '0;
    check("t2_head2", bus.id_o, 2);
    check("t2_count_hold", bus.count_o, 3);
    tick();
    check("t2_head3", bus.id_o, 3);
    tick();
    check("t2_head4", bus.id_o, 4);
    check("t2_data4", bus.data_o, 32'hA5A5_0004);
    check("t2_count1", bus.count_o, 1);
    tick();
    check("t2_empty", bus.v_o, 0);

    // 3: full with simultaneous dequeue
    bus.ready_i = 1'b0;
    for (int i = 8; i < 12; i++) begin
      grant(16'(1 << i));
      tick();
    end
    check("t3_count_full", bus.count_o, 4);
    bus.ready_i = 1'b1;
    grant(16'h8000);
    check("t3_full_yumi", bus.yumi_o, 0);
    check("t3_full_ack", bus.ack_o, 0);
    tick();
    check("t3_count3", bus.count_o, 3);
    check("t3_head9", bus.id_o, 9);
    check("t3_yumi", bus.yumi_o, 1);
    tick();
    bus.grants_i = '0;
    check("t3_count_hold", bus.count_o, 3);
    check("t3_head10", bus.id_o, 10);
    tick();
    check("t3_head11", bus.id_o, 11);
    tick();
    check("t3_head15", bus.id_o, 15);
    check("t3_data15", bus.data_o, 32'hA5A5_000F);
    check("t3_count1", bus.count_o, 1);
    tick();
    check("t3_empty", bus.v_o, 0);

    // 4: streaming, 64 entries through a 4-deep FIFO
    for (int n = 0; n < 64; n++) begin
      grant(16'(1 << (n % 16)));
      check("t4_yumi", bus.yumi_o, 1);
      tick();
      check("t4_v", bus.v_o, 1);
      check("t4_id", bus.id_o, n % 16);
      check("t4_count", bus.count_o, 1);
    end
    bus.grants_i = '0;
    tick();
    check("t4_drained", bus.count_o, 0);

    // 5: multi-hot grant
    bus.ready_i = 1'b0;
    grant(16'h0020);
    tick();
    check("t5_count1", bus.count_o, 1);
    grant(16'h0011);
    check("t5_mh_yumi", bus.yumi_o, 0);
    check("t5_mh_ack", bus.ack_o, 0);
    check("t5_err_not_yet", bus.onehot_err_o, 0);
    tick();
    check("t5_err_set", bus.onehot_err_o, 1);
    check("t5_count_unch", bus.count_o, 1);
    grant(16'h0002);
    check("t5_legal_yumi", bus.yumi_o, 1);
    tick();
    bus.grants_i = '0;
    check("t5_count2", bus.count_o, 2);
    check("t5_err_held", bus.onehot_err_o, 1);
    bus.ready_i = 1'b1;
    #1;
    check("t5_head5", bus.id_o, 5);
    tick();
    check("t5_head1", bus.id_o, 1);
    tick();
    check("t5_empty", bus.v_o, 0);
    check("t5_err_still", bus.onehot_err_o, 1);

    // 6: asynchronous reset mid-cycle
    bus.ready_i = 1'b0;
    for (int i = 8; i < 11; i++) begin
      grant(16'(1 << i));
      tick();
    end
    check("t6_count3", bus.count_o, 3);
    grant(16'h0800);
    check("t6_pre_yumi", bus.yumi_o, 1);
    #1;
    reset = 1'b1;
    #1;
    check("t6_rst_v", bus.v_o, 0);
    check("t6_rst_count", bus.count_o, 0);
    check("t6_rst_yumi", bus.yumi_o, 0);
    check("t6_rst_ack", bus.ack_o, 0);
    check("t6_rst_err", bus.onehot_err_o, 0);
    bus.grants_i = '0;
    #1;
    reset = 1'b0;
    tick();
    check("t6_post_count", bus.count_o, 0);
    grant(16'h0040);
    check("t6_g6_yumi", bus.yumi_o, 1);
    tick();
    bus.grants_i = '0;
    check("t6_v", bus.v_o, 1);
    check("t6_id6", bus.id_o, 6);
    check("t6_count1", bus.count_o, 1);
    bus.ready_i = 1'b1;
    tick();
    check("t6_only_entry", bus.count_o, 0);
    check("t6_empty", bus.v_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
